// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared constants and state encoding for the program loader
package program_loader_pkg;

  // Frame layout constants
  localparam int MAX_LEN        = 32;
  localparam int HDR_TARGET_BIT = 7;
  localparam int HDR_RSVD_MSB   = 6;
  localparam int HDR_RSVD_LSB   = 5;

  // Memory-select encodings driven on mem_sel
  localparam logic MEM_INSTR = 1'b0;
  localparam logic MEM_DATA  = 1'b1;

  // Loader FSM states
  localparam logic [2:0] ST_HDR   = 3'd0;
  localparam logic [2:0] ST_LEN   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  // Reserved header bits must be zero for a frame to be accepted
  function automatic logic hdr_rsvd_ok(input logic [7:0] hdr);
    return hdr[HDR_RSVD_MSB:HDR_RSVD_LSB] == 2'b00;
  endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// rtl/program_loader_checksum.sv - mod-256 frame checksum accumulator
module loader_checksum (
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic       add,
  input  logic [7:0] din,
  output logic       next_zero
);

  logic [7:0] sum;
  logic [7:0] sum_plus;

  // next_zero tells the caller whether the running sum would be zero once din is folded in
  assign sum_plus  = sum + din;
  assign next_zero = (sum_plus == 8'h00);

  // Accumulate: load starts a new frame with the header byte, add folds in later bytes
  always_ff @(posedge clk) begin
    if (clear) begin
      sum <= 8'h00;
    end else if (load) begin
      sum <= din;
    end else if (add) begin
      sum <= sum_plus;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream loader filling instruction/data memories and releasing CPU reset
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              err,
  output logic              frame_ok
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]        state;
  logic              target;
  logic [ADDR_W-1:0] addr;
  logic [5:0]        remaining;
  logic              run_flag;
  logic              accept;
  logic              cks_load;
  logic              cks_add;
  logic              cks_next_zero;

  // Bytes are only taken while a frame is being parsed; RUN and ERROR are terminal
  always_comb begin
    in_ready = (state == ST_HDR) || (state == ST_LEN) ||
               (state == ST_DATA) || (state == ST_CSUM);
  end

  assign accept   = in_valid & in_ready;
  assign cks_load = accept && (state == ST_HDR);
  assign cks_add  = accept && (state != ST_HDR);

  loader_checksum u_checksum (
    .clk       (clk),
    .clear     (reset),
    .load      (cks_load),
    .add       (cks_add),
    .din       (in_data),
    .next_zero (cks_next_zero)
  );

  // Frame parser, address counter and registered memory write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HDR;
      target    <= MEM_INSTR;
      addr      <= '0;
      remaining <= '0;
      run_flag  <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= MEM_INSTR;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      err       <= 1'b0;
      frame_ok  <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      frame_ok <= 1'b0;
      if (accept) begin
        case (state)
          ST_HDR: begin
            if (!hdr_rsvd_ok(in_data)) begin
              state <= ST_ERROR;
              err   <= 1'b1;
            end else begin
              target <= in_data[HDR_TARGET_BIT];
              addr   <= in_data[ADDR_W-1:0];
              state  <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (in_data > MAX_LEN_B) begin
              state <= ST_ERROR;
              err   <= 1'b1;
            end else if (in_data == 8'h00) begin
              run_flag <= 1'b1;
              state    <= ST_CSUM;
            end else begin
              run_flag  <= 1'b0;
              remaining <= in_data[5:0];
              state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            // Writes commit immediately; a later bad checksum does not roll them back
            mem_we    <= 1'b1;
            mem_sel   <= target;
            mem_addr  <= addr;
            mem_wdata <= in_data;
            addr      <= addr + 1'b1;
            remaining <= remaining - 6'd1;
            if (remaining == 6'd1) begin
              state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (!cks_next_zero) begin
              state <= ST_ERROR;
              err   <= 1'b1;
            end else if (run_flag) begin
              state     <= ST_RUN;
              cpu_reset <= 1'b0;
            end else begin
              frame_ok <= 1'b1;
              state    <= ST_HDR;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader against a frame-level model
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic       mem_sel;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset;
  logic       err;
  logic       frame_ok;

  int n_assert = 0;
  int n_fail   = 0;

  // Observed writes and pulses, gathered away from the clock edge
  int         wr_cnt  = 0;
  int         fok_cnt = 0;
  logic [7:0] obs_mem [2][32];

  // Expected memory contents built from frame semantics
  logic [7:0] exp_mem   [2][32];
  bit         exp_valid [2][32];

  program_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .err       (err),
    .frame_ok  (frame_ok)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt = wr_cnt + 1;
      obs_mem[mem_sel][mem_addr] = mem_wdata;
    end
    if (frame_ok) fok_cnt = fok_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] csum_of(input logic [7:0] b[$]);
    int s = 0;
    foreach (b[i]) s += b[i];
    return 8'((256 - (s % 256)) % 256);
  endfunction

  // Send a structurally valid frame, checking each byte's effect as it is accepted
  task automatic send_frame(input logic [7:0] b[$], input int max_gap);
    int   len;
    int   s;
    int   ad;
    logic sel;
    sel = b[0][7];
    len = b[1];
    s   = 0;
    foreach (b[i]) s = (s + b[i]) % 256;
    for (int i = 0; i < b.size(); i++) begin
      for (int g = $urandom_range(0, max_gap); g > 0; g--) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        step(1);
        chk("gap_no_we", mem_we, 0);
      end
      chk("ready_before_byte", in_ready, 1);
      in_valid = 1'b1;
      in_data  = b[i];
      step(1);
      in_valid = 1'b0;
      if (i >= 2 && i < 2 + len) begin
        ad = (int'(b[0][4:0]) + i - 2) % 32;
        chk("we_after_payload", mem_we, 1);
        chk("we_sel", mem_sel, sel);
        chk("we_addr", mem_addr, ad);
        chk("we_data", mem_wdata, b[i]);
        exp_mem[sel][ad]   = b[i];
        exp_valid[sel][ad] = 1'b1;
      end else begin
        chk("no_we_nonpayload", mem_we, 0);
      end
    end
    if (s == 0 && len > 0) begin
      chk("frame_ok_pulse", frame_ok, 1);
      chk("ok_err", err, 0);
      chk("ok_cpu_reset", cpu_reset, 1);
      chk("ok_ready", in_ready, 1);
    end else if (s == 0) begin
      chk("run_cpu_reset", cpu_reset, 0);
      chk("run_ready", in_ready, 0);
      chk("run_frame_ok", frame_ok, 0);
    end else begin
      chk("bad_err", err, 1);
      chk("bad_ready", in_ready, 0);
      chk("bad_cpu_reset", cpu_reset, 1);
      chk("bad_frame_ok", frame_ok, 0);
    end
  endtask

  task automatic random_frame(input int max_gap);
    logic [7:0] fr[$];
    int         len;
    len = $urandom_range(1, 32);
    fr.push_back({1'($urandom), 2'b00, 5'($urandom)});
    fr.push_back(8'(len));
    for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
    fr.push_back(csum_of(fr));
    send_frame(fr, max_gap);
  endtask

  logic [7:0] fr[$];
  int         wr0;
  int         fok0;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    step(2);
    chk("rst_ready", in_ready, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_sel", mem_sel, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_err", err, 0);
    chk("rst_frame_ok", frame_ok, 0);
    reset = 1'b0;

    // Instruction-memory load
    wr0 = wr_cnt; fok0 = fok_cnt;
    fr = '{8'h02, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hE5};
    send_frame(fr, 0);
    step(1);
    chk("t1_writes", wr_cnt - wr0, 3);
    chk("t1_fok_count", fok_cnt - fok0, 1);
    chk("t1_fok_one_cycle", frame_ok, 0);

    // Data-memory load wrapping 31 -> 0
    wr0 = wr_cnt; fok0 = fok_cnt;
    fr = '{8'h9E, 8'h03, 8'h11, 8'h22, 8'h33, 8'hF9};
    send_frame(fr, 0);
    step(1);
    chk("t2_writes", wr_cnt - wr0, 3);
    chk("t2_fok_count", fok_cnt - fok0, 1);
    chk("t2_wrap_mem0", obs_mem[1][0], 8'h33);

    // First frame again with random valid gaps, then random frames
    wr0 = wr_cnt; fok0 = fok_cnt;
    fr = '{8'h02, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hE5};
    send_frame(fr, 3);
    step(1);
    chk("gap_writes", wr_cnt - wr0, 3);
    chk("gap_fok_count", fok_cnt - fok0, 1);
    for (int k = 0; k < 6; k++) random_frame(k % 3);

    // Reset after the second payload byte
    wr0 = wr_cnt;
    fr = '{8'h05, 8'h04, 8'hAA, 8'hBB};
    foreach (fr[i]) begin
      in_valid = 1'b1;
      in_data  = fr[i];
      step(1);
    end
    exp_mem[0][5] = 8'hAA; exp_valid[0][5] = 1'b1;
    exp_mem[0][6] = 8'hBB; exp_valid[0][6] = 1'b1;
    do_reset();
    step(2);
    chk("midrst_writes", wr_cnt - wr0, 2);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_cpu_reset", cpu_reset, 1);
    chk("midrst_we", mem_we, 0);
    fok0 = fok_cnt;
    random_frame(1);
    step(1);
    chk("midrst_next_frame_ok", fok_cnt - fok0, 1);

    // Bad checksum: writes land, then terminal error
    wr0 = wr_cnt; fok0 = fok_cnt;
    fr = '{8'h02, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hE6};
    send_frame(fr, 0);
    in_valid = 1'b1;
    in_data  = 8'h00;
    step(3);
    in_valid = 1'b0;
    chk("bad_writes", wr_cnt - wr0, 3);
    chk("bad_no_fok", fok_cnt - fok0, 0);
    chk("bad_err_sticky", err, 1);
    do_reset();
    chk("bad_rst_err", err, 0);
    chk("bad_rst_ready", in_ready, 1);

    // Reserved header bits set
    wr0 = wr_cnt;
    in_valid = 1'b1;
    in_data  = 8'h40;
    step(1);
    in_valid = 1'b0;
    chk("rsvd_err", err, 1);
    chk("rsvd_ready", in_ready, 0);
    step(1);
    chk("rsvd_writes", wr_cnt - wr0, 0);
    do_reset();

    // Length above 32
    wr0 = wr_cnt;
    in_valid = 1'b1;
    in_data  = 8'h00;
    step(1);
    chk("len_hdr_ok", err, 0);
    in_data = 8'h21;
    step(1);
    in_valid = 1'b0;
    chk("len_err", err, 1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    step(2);
    in_valid = 1'b0;
    chk("len_writes", wr_cnt - wr0, 0);
    do_reset();

    // Valid load followed by RUN
    random_frame(0);
    wr0 = wr_cnt;
    fr = '{8'h00, 8'h00, 8'h00};
    send_frame(fr, 0);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step(1);
      chk("run_no_we", mem_we, 0);
      chk("run_stays", cpu_reset, 0);
      chk("run_not_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    step(1);
    chk("run_writes", wr_cnt - wr0, 0);
    do_reset();
    chk("run_rst_cpu_reset", cpu_reset, 1);
    chk("run_rst_ready", in_ready, 1);

    // Memory image against the frame-level model
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 32; a++)
        if (exp_valid[s][a]) chk($sformatf("mem_%0d_%0d", s, a), obs_mem[s][a], exp_mem[s][a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
